switch_bank_reader: RTL and testbench

//  Memory-mapped reader for the board DIP switches, replacing the raw sampler.

---
 rtl/switch_bank_reader.sv | 99 +++++++++
 tb/tb_switch_bank_reader.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/switch_bank_reader.sv
`default_nettype none
// ==========================================================================
// switch_bank_reader: synchronised, debounced DIP-switch reader with sticky
// per-bit change flags, change IRQ and a two-word memory-mapped read port.
// Revision 1.0
// ==========================================================================
module switch_bank_reader #(
  parameter int SW_WIDTH        = 24,
  parameter int DATA_WIDTH      = 16,
  parameter int DEBOUNCE_CYCLES = 20000,
  parameter int SYNC_STAGES     = 2
) (
  input  logic                  iCpuClock,
  input  logic                  iCpuReset,
  input  logic                  iDoSwitchRead,
  input  logic [1:0]            iSwitchAddress,
  input  logic [SW_WIDTH-1:0]   iFpgaSwitches,
  output logic [DATA_WIDTH-1:0] oSwitchDataRead,
  output logic                  oSwitchChangeIrq
);

  localparam int c_CNT_WIDTH = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [c_CNT_WIDTH-1:0] c_CNT_LAST = c_CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0][SW_WIDTH-1:0] sync_q, sync_d;
  logic [c_CNT_WIDTH-1:0]               cnt_q, cnt_d;
  logic [SW_WIDTH-1:0]                  sample_q, sample_d;
  logic [SW_WIDTH-1:0]                  deb_q, deb_d;
  logic [SW_WIDTH-1:0]                  flags_q, flags_d;
  logic [DATA_WIDTH-1:0]                rd_q, rd_d;
  logic                                 irq_q, irq_d;

  logic                tick;
  logic [SW_WIDTH-1:0] synced;
  logic [SW_WIDTH-1:0] accept;
  logic [SW_WIDTH-1:0] clr;

  always_comb begin
    sync_d   = {sync_q[SYNC_STAGES-2:0], iFpgaSwitches};
    synced   = sync_q[SYNC_STAGES-1];
    tick     = (cnt_q == c_CNT_LAST);
    cnt_d    = tick ? '0 : cnt_q + 1'b1;

    // A bit is accepted only when two consecutive tick samples agree.
    accept   = '0;
    sample_d = sample_q;
    if (tick) begin
      sample_d = synced;
      accept   = ~(synced ^ sample_q) & (synced ^ deb_q);
    end
    deb_d    = deb_q ^ accept;

    clr      = '0;
    rd_d     = rd_q;
    if (iDoSwitchRead) begin
      case (iSwitchAddress)
        2'b00: rd_d = deb_q[DATA_WIDTH-1:0];
        2'b01: rd_d = DATA_WIDTH'(deb_q[SW_WIDTH-1:DATA_WIDTH]);
        2'b10: begin
          rd_d                 = flags_q[DATA_WIDTH-1:0];
          clr[DATA_WIDTH-1:0]  = '1;
        end
        default: begin
          rd_d                       = DATA_WIDTH'(flags_q[SW_WIDTH-1:DATA_WIDTH]);
          clr[SW_WIDTH-1:DATA_WIDTH] = '1;
        end
      endcase
    end

    // New changes override a same-edge clear so no change is lost.
    flags_d  = (flags_q & ~clr) | accept;
    irq_d    = |flags_d;
  end

  always_ff @(negedge iCpuClock or posedge iCpuReset) begin
    if (iCpuReset) begin
      sync_q   <= '0;
      cnt_q    <= '0;
      sample_q <= '0;
      deb_q    <= '0;
      flags_q  <= '0;
      rd_q     <= '0;
      irq_q    <= 1'b0;
    end else begin
      sync_q   <= sync_d;
      cnt_q    <= cnt_d;
      sample_q <= sample_d;
      deb_q    <= deb_d;
      flags_q  <= flags_d;
      rd_q     <= rd_d;
      irq_q    <= irq_d;
    end
  end

  assign oSwitchDataRead  = rd_q;
  assign oSwitchChangeIrq = irq_q;

endmodule
`default_nettype wire

// File: tb/tb_switch_bank_reader.sv
`default_nettype none
// ==========================================================================
// tb_switch_bank_reader: directed self-checking bench for switch_bank_reader.
// Revision 1.0
// ==========================================================================
module tb_switch_bank_reader;

  localparam int SW_WIDTH        = 24;
  localparam int DATA_WIDTH      = 16;
  localparam int DEBOUNCE_CYCLES = 4;
  localparam int SYNC_STAGES     = 2;

  logic                  clk;
  logic                  rst;
  logic                  rd;
  logic [1:0]            addr;
  logic [SW_WIDTH-1:0]   sw;
  logic [DATA_WIDTH-1:0] data;
  logic                  irq;

  int checks;
  int failures;
  int edge_cnt;

  switch_bank_reader #(
    .SW_WIDTH        (SW_WIDTH),
    .DATA_WIDTH      (DATA_WIDTH),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .SYNC_STAGES     (SYNC_STAGES)
  ) dut (
    .iCpuClock        (clk),
    .iCpuReset        (rst),
    .iDoSwitchRead    (rd),
    .iSwitchAddress   (addr),
    .iFpgaSwitches    (sw),
    .oSwitchDataRead  (data),
    .oSwitchChangeIrq (irq)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance past one falling (active) edge; edge_cnt numbers edges since reset release.
  task automatic step();
    @(negedge clk);
    #1;
    edge_cnt++;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic do_read(input logic [1:0] a, output logic [DATA_WIDTH-1:0] d);
    rd   = 1'b1;
    addr = a;
    step();
    rd   = 1'b0;
    d    = data;
  endtask

  task automatic test_reset();
    logic [DATA_WIDTH-1:0] d;
    rst = 1'b1;
    sw  = 24'hFFFFFF;
    rd  = 1'b1;
    addr = 2'b00;
    idle(3);
    checks++;
    if (data !== 16'h0000) begin failures++; $display("FAIL reset_data got=%h exp=0000", data); end
    checks++;
    if (irq !== 1'b0) begin failures++; $display("FAIL reset_irq got=%b exp=0", irq); end
    rd  = 1'b0;
    rst = 1'b0;
    edge_cnt = 0;
    idle(10);
    do_read(2'b00, d);
    checks++;
    if (d !== 16'hFFFF) begin failures++; $display("FAIL reset_acquire got=%h exp=FFFF", d); end
    checks++;
    if (irq !== 1'b1) begin failures++; $display("FAIL reset_irq_set got=%b exp=1", irq); end
    do_read(2'b10, d);
    checks++;
    if (d !== 16'hFFFF) begin failures++; $display("FAIL reset_flags_lo got=%h exp=FFFF", d); end
    do_read(2'b11, d);
    checks++;
    if (d !== 16'h00FF) begin failures++; $display("FAIL reset_flags_hi got=%h exp=00FF", d); end
    step();
    checks++;
    if (irq !== 1'b0) begin failures++; $display("FAIL reset_irq_clear got=%b exp=0", irq); end
  endtask

  task automatic test_all_low();
    logic [DATA_WIDTH-1:0] d;
    sw = 24'h000000;
    idle(11);
    do_read(2'b00, d);
    checks++;
    if (d !== 16'h0000) begin failures++; $display("FAIL low_lo got=%h exp=0000", d); end
    do_read(2'b01, d);
    checks++;
    if (d !== 16'h0000) begin failures++; $display("FAIL low_hi got=%h exp=0000", d); end
    do_read(2'b10, d);
    checks++;
    if (d !== 16'hFFFF) begin failures++; $display("FAIL low_flags_lo got=%h exp=FFFF", d); end
    do_read(2'b11, d);
    checks++;
    if (d !== 16'h00FF) begin failures++; $display("FAIL low_flags_hi got=%h exp=00FF", d); end
    step();
    checks++;
    if (irq !== 1'b0) begin failures++; $display("FAIL low_irq got=%b exp=0", irq); end
  endtask

  task automatic test_glitch();
    logic [DATA_WIDTH-1:0] d;
    logic bad;
    logic bad_val;
    bad = 1'b0;
    bad_val = 1'b0;
    sw = 24'h000008;
    idle(3);
    sw = 24'h000000;
    for (int i = 0; i < 14; i++) begin
      step();
      if (irq !== 1'b0 && !bad) begin bad = 1'b1; bad_val = irq; end
    end
    checks++;
    if (bad) begin failures++; $display("FAIL glitch_irq got=%b exp=0", bad_val); end
    do_read(2'b00, d);
    checks++;
    if (d !== 16'h0000) begin failures++; $display("FAIL glitch_data got=%h exp=0000", d); end
  endtask

  task automatic test_bit20();
    logic [DATA_WIDTH-1:0] d;
    logic got;
    got = 1'b0;
    sw = 24'h100000;
    for (int i = 0; i < 12 && !got; i++) begin
      step();
      if (irq === 1'b1) got = 1'b1;
    end
    checks++;
    if (!got) begin failures++; $display("FAIL bit20_irq got=%b exp=1 within 12 clocks", irq); end
    do_read(2'b11, d);
    checks++;
    if (d !== 16'h0010) begin failures++; $display("FAIL bit20_flags got=%h exp=0010", d); end
    do_read(2'b11, d);
    checks++;
    if (d !== 16'h0000) begin failures++; $display("FAIL bit20_reread got=%h exp=0000", d); end
    step();
    checks++;
    if (irq !== 1'b0) begin failures++; $display("FAIL bit20_irq_drop got=%b exp=0", irq); end
  endtask

  task automatic test_pattern();
    logic [DATA_WIDTH-1:0] d;
    sw = 24'hA51234;
    idle(11);
    do_read(2'b00, d);
    checks++;
    if (d !== 16'h1234) begin failures++; $display("FAIL pat_lo got=%h exp=1234", d); end
    do_read(2'b01, d);
    checks++;
    if (d !== 16'h00A5) begin failures++; $display("FAIL pat_hi got=%h exp=00A5", d); end
    do_read(2'b10, d);
    checks++;
    if (d !== 16'h1234) begin failures++; $display("FAIL pat_flags_lo got=%h exp=1234", d); end
    do_read(2'b11, d);
    checks++;
    if (d !== 16'h00B5) begin failures++; $display("FAIL pat_flags_hi got=%h exp=00B5", d); end
    step();
    checks++;
    if (irq !== 1'b0) begin failures++; $display("FAIL pat_irq got=%b exp=0", irq); end
  endtask

  task automatic test_same_edge();
    logic [DATA_WIDTH-1:0] d;
    int k;
    int t1;
    int acc;
    sw = 24'hA59234;
    idle(11);
    checks++;
    if (irq !== 1'b1) begin failures++; $display("FAIL same_pre_irq got=%b exp=1", irq); end
    sw = 24'hA59235;
    k   = edge_cnt;
    // First tick to see the synced bit is the first multiple of 4 at or after k+3.
    t1  = ((k + 3 + DEBOUNCE_CYCLES - 1) / DEBOUNCE_CYCLES) * DEBOUNCE_CYCLES;
    acc = t1 + DEBOUNCE_CYCLES;
    while (edge_cnt < acc - 1) step();
    do_read(2'b10, d);
    checks++;
    if (d !== 16'h8000) begin failures++; $display("FAIL same_old_flags got=%h exp=8000", d); end
    checks++;
    if (irq !== 1'b1) begin failures++; $display("FAIL same_irq got=%b exp=1", irq); end
    do_read(2'b10, d);
    checks++;
    if (d !== 16'h0001) begin failures++; $display("FAIL same_flag0 got=%h exp=0001", d); end
    step();
    checks++;
    if (irq !== 1'b0) begin failures++; $display("FAIL same_irq_drop got=%b exp=0", irq); end
  endtask

  task automatic test_hold();
    logic [DATA_WIDTH-1:0] d;
    logic bad;
    logic [DATA_WIDTH-1:0] bad_val;
    bad = 1'b0;
    bad_val = '0;
    sw = 24'h000000;
    for (int i = 0; i < 12; i++) begin
      step();
      if (data !== 16'h0001 && !bad) begin bad = 1'b1; bad_val = data; end
    end
    checks++;
    if (bad) begin failures++; $display("FAIL hold_data got=%h exp=0001", bad_val); end
    do_read(2'b00, d);
    checks++;
    if (d !== 16'h0000) begin failures++; $display("FAIL hold_after got=%h exp=0000", d); end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    edge_cnt = 0;
    rst  = 1'b1;
    rd   = 1'b0;
    addr = 2'b00;
    sw   = 24'hFFFFFF;
    test_reset();
    test_all_low();
    test_glitch();
    test_bit20();
    test_pattern();
    test_same_edge();
    test_hold();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
